mux_vector_gen: RTL and testbench
=================================

Name: mux_vector_gen

Overview:
Sequential stimulus sequencer that sits directly upstream of the mux circuit.
- Drives the circuit's 9 data inputs (a..i) and 8 control pins (in1..in8) through an exhaustive count.
- Issues a per-vector sample strobe so a downstream checker knows when the outputs t,n,r,k,m are valid.
- Replaces free-running toggle stimulus with a start/pause/abort-controlled, synthesizable sweep.

Parameters:
DATA_W, 9, width of data vector (bit0=a ... bit8=i)
CTRL_W, 8, width of control vector (bit0=in1 ... bit7=in8)
DWELL, 1, cycles each vector is held before advancing; legal range 1..255

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; honoured only in IDLE or DONE
abort  input  1  terminate sweep, return to IDLE
pause  input  1  freeze sweep position while high
sweep_ctrl  input  1  0: control vector fixed; 1: control vector also counts; latched on start
ctrl_cfg  input  CTRL_W  initial control vector; latched on start
data_vec  output  DATA_W  drives a..i
ctrl_vec  output  CTRL_W  drives in1..in8
vec_valid  output  1  downstream outputs are settled and must be sampled this cycle
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, data_vec=0, ctrl_vec=0, dwell_cnt=0, mode=0, busy=0, done=0, vec_valid=0.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- IDLE/DONE with start=1 and abort=0 at edge:
  - state -> RUN, data_vec=0, ctrl_vec=ctrl_cfg, mode=sweep_ctrl, dwell_cnt=0.
  - First vector is present the cycle after start.
- vec_valid is combinational: (state==RUN) && !pause && (dwell_cnt==DWELL-1).
  - Its only input path is pause; all other terms are registered.
- RUN, at each edge, in priority order:
  1. abort=1: state -> IDLE, data_vec=0, ctrl_vec=0, dwell_cnt=0.
  2. pause=1: hold all state, counters and outputs.
  3. vec_valid=1 and last vector: state -> DONE.
     - Last vector means data_vec all-ones and (mode==0 or ctrl_vec all-ones).
     - data_vec and ctrl_vec hold their final values.
  4. vec_valid=1, not last: dwell_cnt=0 and data_vec+1.
     - If data_vec wraps (all-ones -> 0) and mode==1, ctrl_vec+1.
     - If mode==0, ctrl_vec is unchanged.
  5. Otherwise: dwell_cnt+1.
- start in RUN is ignored. If start and abort are both high: abort wins, and in IDLE/DONE no sweep starts.
- DONE: outputs hold their final vector, vec_valid=0, done=1 until the next start (restart) or abort (-> IDLE).
- Vector counts:
  - mode 0: 2^DATA_W vectors; RUN lasts 2^DATA_W*DWELL cycles plus paused cycles.
  - mode 1: 2^DATA_W*(2^CTRL_W - ctrl_cfg) vectors.
- Counters are modular, unsigned, with no saturation. dwell_cnt is 8 bits.
- DWELL=1: vec_valid is high on every unpaused RUN cycle.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse.

Decomposition:
- Shared package mux_tb_pkg holds:
  - DATA_W/CTRL_W defaults
  - state enum {IDLE, RUN, DONE}
  - the bit-order constants mapping vector bits to a..i and in1..in8
- Optional sub-module: mux_vec_counter, the cascaded data/ctrl counter with wrap and last-vector detect. The FSM and dwell logic stay in the top.

Test Plan:
- DWELL=1, ctrl_cfg=8'h00, sweep_ctrl=0, start pulse:
  - data_vec steps 0..511 on consecutive cycles with vec_valid=1 throughout.
  - done rises exactly 512 cycles after the first vector; ctrl_vec stays 8'h00.
- DWELL=3:
  - vec_valid high only on every third cycle; data_vec changes the cycle after each strobe.
  - Total RUN length 1536 cycles.
- Pause at data_vec=9'd100 for 7 cycles:
  - vec_valid=0 and data_vec=100 during the pause.
  - Resumes at 100 with dwell_cnt intact; done is delayed by exactly 7 cycles.
- sweep_ctrl=1, ctrl_cfg=8'hFE, DWELL=1:
  - At data_vec 511->0, ctrl_vec becomes 8'hFF.
  - done after 1024 vectors; final outputs 9'h1FF / 8'hFF.
- Abort at vector 50 with start also high: next cycle state=IDLE, outputs 0, done=0, no restart. Start in RUN has no effect.
- rst_n low asynchronously mid-cycle at vector 200: outputs go to 0 without waiting for clk. A subsequent start resumes from 0.

Source files
------------

// File: rtl/mux_tb_pkg.sv
// -----------------------------------------------------------------------------
// mux_tb_pkg
// Shared definitions for the mux stimulus sequencer:
//   - default data/control vector widths
//   - sequencer state encoding
//   - bit positions mapping vector bits onto the mux circuit pins
//     (data_vec[BIT_A] drives a ... data_vec[BIT_I] drives i,
//      ctrl_vec[BIT_IN1] drives in1 ... ctrl_vec[BIT_IN8] drives in8)
// -----------------------------------------------------------------------------
package mux_tb_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_CTRL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Data vector bit order: a is the LSB, i the MSB.
  localparam int BIT_A = 0;
  localparam int BIT_B = 1;
  localparam int BIT_C = 2;
  localparam int BIT_D = 3;
  localparam int BIT_E = 4;
  localparam int BIT_F = 5;
  localparam int BIT_G = 6;
  localparam int BIT_H = 7;
  localparam int BIT_I = 8;

  // Control vector bit order: in1 is the LSB, in8 the MSB.
  localparam int BIT_IN1 = 0;
  localparam int BIT_IN2 = 1;
  localparam int BIT_IN3 = 2;
  localparam int BIT_IN4 = 3;
  localparam int BIT_IN5 = 4;
  localparam int BIT_IN6 = 5;
  localparam int BIT_IN7 = 6;
  localparam int BIT_IN8 = 7;

endpackage

// File: rtl/mux_vector_gen_counter.sv
// -----------------------------------------------------------------------------
// mux_vec_counter
// Combinational next-vector logic for the cascaded data/control counter.
// The data vector always increments; the control vector increments only on a
// data wrap (all-ones -> 0) when control sweeping is enabled.
// Ports:
//   data      current data vector
//   ctrl      current control vector
//   mode      1: control vector counts on data wrap; 0: control held
//   data_next data vector after one step (modular)
//   ctrl_next control vector after one step (modular)
//   last      current vector is the final one of the sweep
// -----------------------------------------------------------------------------
module mux_vec_counter
  import mux_tb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              mode,
  output logic [DATA_W-1:0] data_next,
  output logic [CTRL_W-1:0] ctrl_next,
  output logic              last
);

  logic data_wrap;

  assign data_wrap = &data;
  assign data_next = data + DATA_W'(1);
  assign ctrl_next = (mode && data_wrap) ? ctrl + CTRL_W'(1) : ctrl;
  // In fixed-control mode the sweep ends after one pass of the data vector.
  assign last      = data_wrap && (!mode || (&ctrl));

endmodule

// File: rtl/mux_vector_gen.sv
// -----------------------------------------------------------------------------
// mux_vector_gen
// Start/pause/abort controlled exhaustive stimulus sequencer for the mux
// circuit. Each vector is held DWELL cycles; vec_valid marks the last cycle of
// the dwell, when the downstream outputs (t,n,r,k,m) are to be sampled.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       begin a sweep (honoured in IDLE or DONE only)
//   abort       stop the sweep and return to IDLE; wins over start
//   pause       freeze sweep position while high
//   sweep_ctrl  latched on start: 1 = control vector also counts
//   ctrl_cfg    latched on start: initial control vector
//   data_vec    drives a..i
//   ctrl_vec    drives in1..in8
//   vec_valid   sample strobe for downstream checker
//   busy, done  state flags (RUN, DONE)
// -----------------------------------------------------------------------------
module mux_vector_gen
  import mux_tb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DWELL  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              sweep_ctrl,
  input  logic [CTRL_W-1:0] ctrl_cfg,
  output logic [DATA_W-1:0] data_vec,
  output logic [CTRL_W-1:0] ctrl_vec,
  output logic              vec_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t            state;
  logic              mode;
  logic [7:0]        dwell_cnt;
  logic [DATA_W-1:0] data_next;
  logic [CTRL_W-1:0] ctrl_next;
  logic              last;

  mux_vec_counter #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_counter (
    .data      (data_vec),
    .ctrl      (ctrl_vec),
    .mode      (mode),
    .data_next (data_next),
    .ctrl_next (ctrl_next),
    .last      (last)
  );

  // pause is the only unregistered term, so the strobe drops in the same
  // cycle a pause is requested.
  assign vec_valid = (state == RUN) && !pause && (dwell_cnt == DWELL_LAST);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode      <= 1'b0;
      dwell_cnt <= '0;
      data_vec  <= '0;
      ctrl_vec  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (abort) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            data_vec  <= '0;
            ctrl_vec  <= '0;
          end else if (start) begin
            state     <= RUN;
            mode      <= sweep_ctrl;
            dwell_cnt <= '0;
            data_vec  <= '0;
            ctrl_vec  <= ctrl_cfg;
          end
        end

        RUN: begin
          if (abort) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            data_vec  <= '0;
            ctrl_vec  <= '0;
          end else if (pause) begin
            // Hold everything, including the partially elapsed dwell.
          end else if (vec_valid) begin
            if (last) begin
              // Final vector stays on the outputs through DONE.
              state <= DONE;
            end else begin
              dwell_cnt <= '0;
              data_vec  <= data_next;
              ctrl_vec  <= ctrl_next;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_vector_gen.sv
// -----------------------------------------------------------------------------
// tb_mux_vector_gen
// Directed bench for mux_vector_gen. Two instances share abort/pause/config
// inputs and have separate start pulses: u_dut1 (DWELL=1) and u_dut3 (DWELL=3).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mux_vector_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start3;
  logic       abort, pause, sweep_ctrl;
  logic [7:0] ctrl_cfg;

  logic [8:0] data1, data3;
  logic [7:0] ctrl1, ctrl3;
  logic       valid1, valid3, busy1, busy3, done1, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_vector_gen #(.DATA_W(9), .CTRL_W(8), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .pause(pause),
    .sweep_ctrl(sweep_ctrl), .ctrl_cfg(ctrl_cfg),
    .data_vec(data1), .ctrl_vec(ctrl1), .vec_valid(valid1),
    .busy(busy1), .done(done1)
  );

  mux_vector_gen #(.DATA_W(9), .CTRL_W(8), .DWELL(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .pause(pause),
    .sweep_ctrl(sweep_ctrl), .ctrl_cfg(ctrl_cfg),
    .data_vec(data3), .ctrl_vec(ctrl3), .vec_valid(valid3),
    .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    start1     = 1'b0;
    start3     = 1'b0;
    abort      = 1'b0;
    pause      = 1'b0;
    sweep_ctrl = 1'b0;
    ctrl_cfg   = 8'h00;

    // ---- reset state ----
    #12;
    check("rst_data1",  32'(data1),  32'h0);
    check("rst_ctrl1",  32'(ctrl1),  32'h0);
    check("rst_valid1", 32'(valid1), 32'h0);
    check("rst_busy1",  32'(busy1),  32'h0);
    check("rst_done1",  32'(done1),  32'h0);
    check("rst_data3",  32'(data3),  32'h0);
    check("rst_busy3",  32'(busy3),  32'h0);
    #5 rst_n = 1'b1;
    tick();
    check("idle_busy1", 32'(busy1), 32'h0);

    // ---- DWELL=1, mode 0, ctrl_cfg=0: 512 vectors on consecutive cycles ----
    ctrl_cfg   = 8'h00;
    sweep_ctrl = 1'b0;
    start1     = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 512; c++) begin
      check("m0_data",  32'(data1),  32'(c));
      check("m0_valid", 32'(valid1), 32'h1);
      check("m0_ctrl",  32'(ctrl1),  32'h0);
      check("m0_done",  32'(done1),  32'h0);
      tick();
    end
    check("m0_done_rise", 32'(done1),  32'h1);
    check("m0_busy_end",  32'(busy1),  32'h0);
    check("m0_final",     32'(data1),  32'h1FF);
    check("m0_valid_end", 32'(valid1), 32'h0);

    // ---- DWELL=3: strobe every third cycle, 1536-cycle run ----
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 0; c < 1536; c++) begin
      check("d3_data",  32'(data3),  32'(c / 3));
      check("d3_valid", 32'(valid3), 32'((c % 3) == 2));
      check("d3_busy",  32'(busy3),  32'h1);
      tick();
    end
    check("d3_done", 32'(done3), 32'h1);
    check("d3_last", 32'(data3), 32'h1FF);

    // ---- DWELL=3 with a 7-cycle pause entered mid-dwell at data 100 ----
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 0; c < 1543; c++) begin
      int k;
      pause = (c >= 301) && (c <= 307);
      #1;
      k = (c < 301) ? c : ((c <= 307) ? 301 : c - 7);
      check("p_data",  32'(data3),  32'(k / 3));
      check("p_valid", 32'(valid3), 32'(!pause && ((k % 3) == 2)));
      check("p_done",  32'(done3),  32'h0);
      tick();
    end
    pause = 1'b0;
    check("p_done_delayed", 32'(done3), 32'h1);

    // ---- mode 1, ctrl_cfg=FE, DWELL=1: 1024 vectors ----
    ctrl_cfg   = 8'hFE;
    sweep_ctrl = 1'b1;
    start1     = 1'b1;
    tick();
    start1     = 1'b0;
    ctrl_cfg   = 8'h00;
    sweep_ctrl = 1'b0;
    for (int v = 0; v < 1024; v++) begin
      check("m1_data",  32'(data1),  32'(v % 512));
      check("m1_ctrl",  32'(ctrl1),  32'((v < 512) ? 8'hFE : 8'hFF));
      check("m1_valid", 32'(valid1), 32'h1);
      tick();
    end
    check("m1_done",       32'(done1), 32'h1);
    check("m1_final_data", 32'(data1), 32'h1FF);
    check("m1_final_ctrl", 32'(ctrl1), 32'hFF);
    tick();
    check("m1_hold_done",  32'(done1),  32'h1);
    check("m1_hold_valid", 32'(valid1), 32'h0);
    check("m1_hold_ctrl",  32'(ctrl1),  32'hFF);

    // ---- start ignored in RUN, then abort+start at vector 50 ----
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 50; c++) begin
      start1 = (c == 10);
      #1;
      check("ab_data", 32'(data1), 32'(c));
      tick();
    end
    start1 = 1'b0;
    check("ab_at50", 32'(data1), 32'd50);
    abort  = 1'b1;
    start1 = 1'b1;
    tick();
    abort  = 1'b0;
    start1 = 1'b0;
    check("ab_busy", 32'(busy1), 32'h0);
    check("ab_done", 32'(done1), 32'h0);
    check("ab_data0", 32'(data1), 32'h0);
    check("ab_ctrl0", 32'(ctrl1), 32'h0);
    check("ab_done3_idle", 32'(done3), 32'h0);
    tick();
    check("ab_no_restart", 32'(busy1), 32'h0);

    // ---- async reset mid-cycle at vector 200 ----
    ctrl_cfg = 8'h35;
    start1   = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (200) tick();
    check("rs_at200", 32'(data1), 32'd200);
    check("rs_ctrl",  32'(ctrl1), 32'h35);
    #2 rst_n = 1'b0;
    #1;
    check("rs_async_data", 32'(data1), 32'h0);
    check("rs_async_ctrl", 32'(ctrl1), 32'h0);
    check("rs_async_busy", 32'(busy1), 32'h0);
    check("rs_async_done", 32'(done1), 32'h0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("rs_idle_busy", 32'(busy1), 32'h0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("rs_restart_data", 32'(data1), 32'h0);
    check("rs_restart_ctrl", 32'(ctrl1), 32'h35);
    check("rs_restart_busy", 32'(busy1), 32'h1);
    tick();
    check("rs_step", 32'(data1), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
